// File: rtl/a_skew_feeder.sv
// West-edge feeder for sys_array: accepts one A column vector per cycle and skews it diagonally
// so mesh row m sees its slice m cycles later, then drains and pulses done after the last beat.
module a_skew_feeder #(
  parameter int unsigned MESHROWS = 4,
  parameter int unsigned TILEROWS = 1,
  parameter int unsigned BITWIDTH = 8
) (
  input  logic                                                clock,
  input  logic                                                reset,
  input  logic signed [MESHROWS-1:0][TILEROWS-1:0][BITWIDTH-1:0] in_vec,
  input  logic                                                in_valid,
  input  logic                                                in_last,
  output logic                                                in_ready,
  output logic signed [MESHROWS-1:0][TILEROWS-1:0][BITWIDTH-1:0] out_a,
  output logic        [MESHROWS-1:0]                          out_a_valid,
  output logic                                                busy,
  output logic                                                done
);

  localparam int unsigned CntW = $clog2(MESHROWS) + 1;

  typedef enum logic {StStream, StDrain} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              accept;

  assign in_ready = (state_q == StStream);
  assign busy     = (state_q == StDrain);
  assign done     = busy && (cnt_q == '0);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StStream: begin
        if (accept && in_last) begin
          state_d = StDrain;
          cnt_d   = CntW'(MESHROWS - 1);
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
          state_d = StStream;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StStream;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Row m is an (m+1)-deep shift chain; stage 0 loads a bubble (zero, invalid) when nothing
  // is accepted so idle slots never show stale data.
  for (genvar m = 0; m < MESHROWS; m++) begin : g_row
    logic [m:0][TILEROWS-1:0][BITWIDTH-1:0] data_q;
    logic [m:0]                             vld_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        data_q <= '0;
        vld_q  <= '0;
      end else begin
        data_q[0] <= accept ? in_vec[m] : '0;
        vld_q[0]  <= accept;
        for (int d = 1; d <= m; d++) begin
          data_q[d] <= data_q[d-1];
          vld_q[d]  <= vld_q[d-1];
        end
      end
    end

    assign out_a[m]       = data_q[m];
    assign out_a_valid[m] = vld_q[m];
  end

endmodule

// File: tb/tb_a_skew_feeder.sv
// Directed bench for a_skew_feeder (3 mesh rows, 2 tile rows, 8-bit elements): a per-cycle
// vector table plus hand-written single-beat and negative-value sequences.
module tb_a_skew_feeder;

  localparam int unsigned MR = 3;
  localparam int unsigned TR = 2;
  localparam int unsigned BW = 8;

  logic                                clock;
  logic                                reset;
  logic signed [MR-1:0][TR-1:0][BW-1:0] in_vec;
  logic                                in_valid;
  logic                                in_last;
  logic                                in_ready;
  logic signed [MR-1:0][TR-1:0][BW-1:0] out_a;
  logic        [MR-1:0]                out_a_valid;
  logic                                busy;
  logic                                done;

  int total;
  int bad;

  a_skew_feeder #(
    .MESHROWS(MR),
    .TILEROWS(TR),
    .BITWIDTH(BW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_vec     (in_vec),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_a      (out_a),
    .out_a_valid(out_a_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One record per clock edge: inputs applied before the edge, outputs expected after it.
  // Every element of a row carries the same value in these records.
  typedef struct {
    bit         rst;
    logic [7:0] val;
    bit         vld;
    bit         lst;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [2:0] ev;
    bit         rdy;
    bit         bsy;
    bit         dn;
  } rec_t;

  rec_t tbl[$];

  function automatic rec_t mk(bit rst, logic [7:0] val, bit vld, bit lst, logic [7:0] e0,
                              logic [7:0] e1, logic [7:0] e2, logic [2:0] ev, bit rdy, bit bsy,
                              bit dn);
    rec_t r;
    r.rst = rst; r.val = val; r.vld = vld; r.lst = lst;
    r.e0 = e0; r.e1 = e1; r.e2 = e2; r.ev = ev;
    r.rdy = rdy; r.bsy = bsy; r.dn = dn;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int m = 0; m < MR; m++)
      for (int t = 0; t < TR; t++)
        in_vec[m][t] = v;
  endtask

  task automatic check_ctl(input string tag, input logic [2:0] ev, input bit rdy, input bit bsy,
                           input bit dn);
    check({tag, " valid"}, int'(out_a_valid), int'(ev));
    check({tag, " in_ready"}, int'(in_ready), int'(rdy));
    check({tag, " busy"}, int'(busy), int'(bsy));
    check({tag, " done"}, int'(done), int'(dn));
  endtask

  initial begin
    logic [7:0] exp_row [MR];
    int         ready_low;

    total = 0;
    bad   = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    fill(8'h00);
    step();
    step();

    // Reset state, then back-to-back V0..V3 with last on V3.
    tbl.push_back(mk(1, 8'd0,  0, 0, 8'd0,  8'd0,  8'd0,  3'b000, 1, 0, 0));
    tbl.push_back(mk(0, 8'd10, 1, 0, 8'd10, 8'd0,  8'd0,  3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 8'd11, 1, 0, 8'd11, 8'd10, 8'd0,  3'b011, 1, 0, 0));
    tbl.push_back(mk(0, 8'd12, 1, 0, 8'd12, 8'd11, 8'd10, 3'b111, 1, 0, 0));
    tbl.push_back(mk(0, 8'd13, 1, 1, 8'd13, 8'd12, 8'd11, 3'b111, 0, 1, 0));
    tbl.push_back(mk(0, 8'd0,  0, 0, 8'd0,  8'd13, 8'd12, 3'b110, 0, 1, 0));
    tbl.push_back(mk(0, 8'd0,  0, 0, 8'd0,  8'd0,  8'd13, 3'b100, 0, 1, 1));
    tbl.push_back(mk(0, 8'd0,  0, 0, 8'd0,  8'd0,  8'd0,  3'b000, 1, 0, 0));
    // Bubble between V0 and V1.
    tbl.push_back(mk(1, 8'd0,  0, 0, 8'd0,  8'd0,  8'd0,  3'b000, 1, 0, 0));
    tbl.push_back(mk(0, 8'd20, 1, 0, 8'd20, 8'd0,  8'd0,  3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 8'd99, 0, 1, 8'd0,  8'd20, 8'd0,  3'b010, 1, 0, 0));
    tbl.push_back(mk(0, 8'd21, 1, 1, 8'd21, 8'd0,  8'd20, 3'b101, 0, 1, 0));
    tbl.push_back(mk(0, 8'd0,  0, 0, 8'd0,  8'd21, 8'd0,  3'b010, 0, 1, 0));
    tbl.push_back(mk(0, 8'd0,  0, 0, 8'd0,  8'd0,  8'd21, 3'b100, 0, 1, 1));
    tbl.push_back(mk(0, 8'd0,  0, 0, 8'd0,  8'd0,  8'd0,  3'b000, 1, 0, 0));
    // Backpressure: next beat held through DRAIN, taken once on the edge after the done cycle.
    tbl.push_back(mk(0, 8'd30, 1, 1, 8'd30, 8'd0,  8'd0,  3'b001, 0, 1, 0));
    tbl.push_back(mk(0, 8'd31, 1, 0, 8'd0,  8'd30, 8'd0,  3'b010, 0, 1, 0));
    tbl.push_back(mk(0, 8'd31, 1, 0, 8'd0,  8'd0,  8'd30, 3'b100, 0, 1, 1));
    tbl.push_back(mk(0, 8'd31, 1, 0, 8'd0,  8'd0,  8'd0,  3'b000, 1, 0, 0));
    tbl.push_back(mk(0, 8'd31, 1, 0, 8'd31, 8'd0,  8'd0,  3'b001, 1, 0, 0));
    tbl.push_back(mk(0, 8'd0,  0, 0, 8'd0,  8'd31, 8'd0,  3'b010, 1, 0, 0));
    tbl.push_back(mk(0, 8'd0,  0, 0, 8'd0,  8'd0,  8'd31, 3'b100, 1, 0, 0));
    tbl.push_back(mk(0, 8'd0,  0, 0, 8'd0,  8'd0,  8'd0,  3'b000, 1, 0, 0));
    // Reset in the second DRAIN cycle, with a beat presented during reset.
    tbl.push_back(mk(0, 8'd40, 1, 1, 8'd40, 8'd0,  8'd0,  3'b001, 0, 1, 0));
    tbl.push_back(mk(0, 8'd0,  0, 0, 8'd0,  8'd40, 8'd0,  3'b010, 0, 1, 0));
    tbl.push_back(mk(1, 8'd41, 1, 1, 8'd0,  8'd0,  8'd0,  3'b000, 1, 0, 0));
    tbl.push_back(mk(0, 8'd0,  0, 0, 8'd0,  8'd0,  8'd0,  3'b000, 1, 0, 0));
    tbl.push_back(mk(0, 8'd0,  0, 0, 8'd0,  8'd0,  8'd0,  3'b000, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      reset    = tbl[i].rst;
      in_valid = tbl[i].vld;
      in_last  = tbl[i].lst;
      fill(tbl[i].val);
      step();
      exp_row[0] = tbl[i].e0;
      exp_row[1] = tbl[i].e1;
      exp_row[2] = tbl[i].e2;
      for (int m = 0; m < MR; m++)
        for (int t = 0; t < TR; t++)
          check($sformatf("rec%0d out_a[%0d][%0d]", i, m, t), int'(out_a[m][t]),
                int'(exp_row[m]));
      check_ctl($sformatf("rec%0d", i), tbl[i].ev, tbl[i].rdy, tbl[i].bsy, tbl[i].dn);
    end

    // Single beat with distinct elements per row and tile.
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; fill(8'h00);
    step();
    reset = 1'b0;
    in_vec[0][0] = 8'd1; in_vec[0][1] = 8'd2;
    in_vec[1][0] = 8'd3; in_vec[1][1] = 8'd4;
    in_vec[2][0] = 8'd5; in_vec[2][1] = 8'd6;
    in_valid = 1'b1; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0; fill(8'h00);
    check("single e0 r0t0", int'(out_a[0][0]), 1);
    check("single e0 r0t1", int'(out_a[0][1]), 2);
    check_ctl("single e0", 3'b001, 0, 1, 0);
    ready_low = (in_ready == 1'b0) ? 1 : 0;
    step();
    check("single e1 r1t0", int'(out_a[1][0]), 3);
    check("single e1 r1t1", int'(out_a[1][1]), 4);
    check("single e1 r0t0", int'(out_a[0][0]), 0);
    check_ctl("single e1", 3'b010, 0, 1, 0);
    if (in_ready == 1'b0) ready_low++;
    step();
    check("single e2 r2t0", int'(out_a[2][0]), 5);
    check("single e2 r2t1", int'(out_a[2][1]), 6);
    check("single e2 r1t0", int'(out_a[1][0]), 0);
    check_ctl("single e2", 3'b100, 0, 1, 1);
    if (in_ready == 1'b0) ready_low++;
    step();
    if (in_ready == 1'b0) ready_low++;
    check_ctl("single e3", 3'b000, 1, 0, 0);
    check("single ready-low cycles", ready_low, 3);

    // Most negative element must arrive bit-exact and read as -128 when taken signed.
    fill(8'h80); in_valid = 1'b1; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0; fill(8'h00);
    for (int m = 0; m < MR; m++) begin
      for (int t = 0; t < TR; t++) begin
        check($sformatf("neg row%0d tile%0d", m, t), int'($signed(out_a[m][t])), -128);
        check($sformatf("neg raw row%0d tile%0d", m, t), int'(out_a[m][t]), 128);
      end
      check($sformatf("neg valid row%0d", m), int'(out_a_valid[m]), 1);
      step();
    end
    check_ctl("neg end", 3'b000, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
